seven_seg_time_decoder: RTL and testbench
=========================================

# seven_seg_time_decoder

Reads back the six seven-segment digit buses driven by the stopwatch display path and recovers the binary minutes, seconds and hundredths counts. It performs the inverse of the binary-to-BCD-to-segment encoding: validates each segment pattern, maps it to a BCD digit, then runs a sequential reverse double-dabble to binary. It is used for display self-check and for lap-time capture from the display bus, with a start/busy/done handshake.

## Interface
- No parameters; widths are fixed by the package.
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request, sampled in IDLE only.
- hex_10_mins, hex_1_min, hex_10_secs, hex_1_sec, hex_tenths, hex_hundredths  in  8 each  active-low segment patterns; bit0..6 = a..g, bit7 = decimal point (ignored).
- busy  out  1  high in DECODE, CONVERT, DONE.
- done  out  1  one-cycle completion pulse.
- error  out  1  last conversion rejected; valid from done until the next start.
- bad_digit  out  6  per-digit invalid mask {10m,1m,10s,1s,tenths,hundredths}.
- stopwatch_unit_mins  out  7  recovered minutes, 0..99.
- stopwatch_unit_secs  out  6  recovered seconds, 0..59.
- stopwatch_unit_decs  out  7  recovered hundredths, 0..99.

## Operation
- States: IDLE, DECODE, CONVERT, DONE.
- IDLE: on start=1, register all six input buses and go to DECODE.
- DECODE: invert bits[6:0]; match the active-high codes 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D or 0x7C, 7=0x07 or 0x27, 8=0x7F, 9=0x6F or 0x67. Any other code sets that digit's bad_digit bit. A 10-secs digit greater than 5 also sets its bit. Then go to DONE if the mask is nonzero, else to CONVERT with the iteration counter at 0.
- CONVERT: three 8-bit BCD pairs are converted in parallel by reverse double-dabble. Each cycle:
  - shift {BCD, binary} right by 1;
  - subtract 3 from each BCD nibble that is ≥8.
  - Exactly 7 iterations; counter 0..6, then go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
  - On success: load the binary outputs and clear error.
  - On error: the binary outputs hold their previous values, error=1, and bad_digit holds the mask.
- start while busy is ignored and is not queued.
- Binary outputs change only in DONE after a successful conversion.

## Timing
- Reset values: state IDLE; busy, done, error = 0; bad_digit = 0; all binary outputs 0.
- Valid path: start sampled at edge E0. DECODE follows E0, CONVERT follows E1 through E7, and DONE follows E8. done is high in the cycle after E8, which is 9 cycles after start.
- Error path: done is high in the cycle after E1, 2 cycles after start.
- Back-to-back: start may be asserted in the cycle done is high, but it is not sampled until IDLE. The minimum period is therefore 10 cycles.
- reset_n low mid-operation: immediate return to reset values; the partial result is discarded.
- Input buses may change after E0 without effect.

## Configuration
- SEG_DECODER_BLANK_ZERO_EN
  - Defined: an all-segments-off pattern (0x7F/0xFF on the wire) on any tens digit (10m, 10s, tenths) decodes as 0 and is not flagged. This covers leading-zero blanking.
  - Undefined: a blank pattern on any digit is invalid and sets its bad_digit bit.

## Structure
- Package seven_seg_time_pkg holds:
  - the ten segment code constants and their alternates;
  - the state enum;
  - width constants: MINS_W=7, SECS_W=6, DECS_W=7, ITER=7.
- Sub-module seg_pattern_decoder: combinational 7-bit active-high pattern in; 4-bit BCD and invalid flag out. Instantiated six times.

## Test plan
- "12:34.56": inputs 0xF9, 0xA4, 0xB0, 0x99, 0x92, 0x82, start pulse → done 9 cycles later, mins=12, secs=34, decs=56, error=0.
- Maximum "99:59.99": all digits 0x90 except 10s=0x92 → mins=99, secs=59, decs=99.
- 10-secs showing 6 (0x82) → done 2 cycles after start, error=1, bad_digit=6'b001000, binary outputs unchanged from the previous run.
- 1-min digit garbage 0xFE, valid everywhere else → error=1, bad_digit=6'b010000.
- Leading blank 0xFF on 10m with "-:05.07" → with the macro: mins=0…, error=0; without: error=1, bad_digit=6'b100000.
- reset_n pulsed low during CONVERT; start asserted again during busy → outputs zero with no done pulse; start during busy is ignored with exactly one done per accepted start.

Source files
------------

// File: rtl/seven_seg_time_decoder_pkg.sv
// Shared types and constants for the seven-segment time read-back decoder.
// Segment codes are active-high, bit0..6 = a..g.
package seven_seg_time_pkg;

  localparam int unsigned MINS_W     = 7;
  localparam int unsigned SECS_W     = 6;
  localparam int unsigned DECS_W     = 7;
  localparam int unsigned ITER       = 7;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned ITER_W     = 3;
  localparam logic [ITER_W-1:0] ITER_LAST = 3'(ITER - 1);

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StConvert,
    StDone
  } state_e;

  // Two BCD digits plus the binary value being assembled from the top down.
  typedef struct packed {
    logic [7:0] bcd;
    logic [6:0] bin;
  } dd_pair_t;

  // One reverse double-dabble step: shift right, then undo the x2 on each nibble >= 8.
  function automatic dd_pair_t dd_step(input dd_pair_t p);
    dd_pair_t r;
    r = dd_pair_t'({p.bcd, p.bin} >> 1);
    if (r.bcd[7:4] >= 4'd8) r.bcd[7:4] = r.bcd[7:4] - 4'd3;
    if (r.bcd[3:0] >= 4'd8) r.bcd[3:0] = r.bcd[3:0] - 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_time_decoder_if.sv
// Handshake and display bus between the stopwatch display path and the decoder.
interface seven_seg_time_decoder_if;
  import seven_seg_time_pkg::*;

  logic                  start;
  logic [7:0]            hex_10_mins;
  logic [7:0]            hex_1_min;
  logic [7:0]            hex_10_secs;
  logic [7:0]            hex_1_sec;
  logic [7:0]            hex_tenths;
  logic [7:0]            hex_hundredths;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [NUM_DIGITS-1:0] bad_digit;
  logic [MINS_W-1:0]     stopwatch_unit_mins;
  logic [SECS_W-1:0]     stopwatch_unit_secs;
  logic [DECS_W-1:0]     stopwatch_unit_decs;

  modport master (
    output start, hex_10_mins, hex_1_min, hex_10_secs, hex_1_sec, hex_tenths, hex_hundredths,
    input  busy, done, error, bad_digit,
    input  stopwatch_unit_mins, stopwatch_unit_secs, stopwatch_unit_decs
  );

  modport slave (
    input  start, hex_10_mins, hex_1_min, hex_10_secs, hex_1_sec, hex_tenths, hex_hundredths,
    output busy, done, error, bad_digit,
    output stopwatch_unit_mins, stopwatch_unit_secs, stopwatch_unit_decs
  );

endinterface

// File: rtl/seg_pattern_decoder.sv
// Maps one active-high seven-segment pattern to its BCD digit; unknown patterns are flagged.
module seg_pattern_decoder
  import seven_seg_time_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       invalid_o
);

  always_comb begin
    bcd_o     = 4'd0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:            bcd_o = 4'd0;
      SEG_1:            bcd_o = 4'd1;
      SEG_2:            bcd_o = 4'd2;
      SEG_3:            bcd_o = 4'd3;
      SEG_4:            bcd_o = 4'd4;
      SEG_5:            bcd_o = 4'd5;
      SEG_6, SEG_6_ALT: bcd_o = 4'd6;
      SEG_7, SEG_7_ALT: bcd_o = 4'd7;
      SEG_8:            bcd_o = 4'd8;
      SEG_9, SEG_9_ALT: bcd_o = 4'd9;
      default:          invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_time_decoder.sv
// Recovers binary mins/secs/hundredths from six active-low segment buses.
// Optional SEG_DECODER_BLANK_ZERO_EN: blank tens digits decode as 0.
module seven_seg_time_decoder
  import seven_seg_time_pkg::*;
(
  input logic                      clock,
  input logic                      reset_n,
  seven_seg_time_decoder_if.slave  bus
);

  // Digit index 5..0 = 10m, 1m, 10s, 1s, tenths, hundredths (matches bad_digit order).
  logic [NUM_DIGITS-1:0][7:0] hex_in;
  logic [NUM_DIGITS-1:0][6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0][3:0] dec_bcd, digit_bcd;
  logic [NUM_DIGITS-1:0]      dec_inv, digit_bad;
  logic                       unused_dp;

  state_e                state_q, state_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  dd_pair_t [2:0]        pair_q, pair_d, pair_step;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [NUM_DIGITS-1:0] bad_q, bad_d;
  logic [MINS_W-1:0]     mins_q, mins_d;
  logic [SECS_W-1:0]     secs_q, secs_d;
  logic [DECS_W-1:0]     decs_q, decs_d;

  assign hex_in = {bus.hex_10_mins, bus.hex_1_min, bus.hex_10_secs,
                   bus.hex_1_sec, bus.hex_tenths, bus.hex_hundredths};
  assign unused_dp = ^{hex_in[5][7], hex_in[4][7], hex_in[3][7],
                       hex_in[2][7], hex_in[1][7], hex_in[0][7]};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg_pattern_decoder u_dec (
      .seg_i     (seg_q[i]),
      .bcd_o     (dec_bcd[i]),
      .invalid_o (dec_inv[i])
    );
  end

  always_comb begin
    digit_bcd = dec_bcd;
    digit_bad = dec_inv;
`ifdef SEG_DECODER_BLANK_ZERO_EN
    // Leading-zero blanking only ever applies to the tens position of each pair.
    for (int i = 1; i < NUM_DIGITS; i += 2) begin
      if (seg_q[i] == SEG_BLANK) begin
        digit_bcd[i] = 4'd0;
        digit_bad[i] = 1'b0;
      end
    end
`endif
    if (digit_bcd[3] > 4'd5) digit_bad[3] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < 3; p++) pair_step[p] = dd_step(pair_q[p]);
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    seg_d   = seg_q;
    pair_d  = pair_q;
    done_d  = 1'b0;
    error_d = error_q;
    bad_d   = bad_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    decs_d  = decs_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_DIGITS; i++) seg_d[i] = ~hex_in[i][6:0];
          error_d = 1'b0;
          bad_d   = '0;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (|digit_bad) begin
          bad_d   = digit_bad;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          pair_d[2] = '{bcd: {digit_bcd[5], digit_bcd[4]}, bin: '0};
          pair_d[1] = '{bcd: {digit_bcd[3], digit_bcd[2]}, bin: '0};
          pair_d[0] = '{bcd: {digit_bcd[1], digit_bcd[0]}, bin: '0};
          iter_d    = '0;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        pair_d = pair_step;
        if (iter_q == ITER_LAST) begin
          mins_d  = pair_step[2].bin;
          secs_d  = pair_step[1].bin[SECS_W-1:0];
          decs_d  = pair_step[0].bin;
          error_d = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      iter_q  <= '0;
      seg_q   <= '0;
      pair_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      bad_q   <= '0;
      mins_q  <= '0;
      secs_q  <= '0;
      decs_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      seg_q   <= seg_d;
      pair_q  <= pair_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      bad_q   <= bad_d;
      mins_q  <= mins_d;
      secs_q  <= secs_d;
      decs_q  <= decs_d;
    end
  end

  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.error               = error_q;
  assign bus.bad_digit           = bad_q;
  assign bus.stopwatch_unit_mins = mins_q;
  assign bus.stopwatch_unit_secs = secs_q;
  assign bus.stopwatch_unit_decs = decs_q;

endmodule

// File: tb/tb_seven_seg_time_decoder.sv
// Scoreboard bench for seven_seg_time_decoder: directed display patterns, error paths,
// reset mid-conversion and start-while-busy.
module tb_seven_seg_time_decoder;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  seven_seg_time_decoder_if bus ();

  seven_seg_time_decoder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string       name;
    int unsigned start_cyc;
    int unsigned lat;
    logic        err;
    logic [5:0]  bad;
    int unsigned mins;
    int unsigned secs;
    int unsigned decs;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors    = 0;
  int unsigned checks    = 0;
  int unsigned cyc       = 0;
  int unsigned done_seen = 0;
  int unsigned accepted  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && bus.done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, ".latency"}, cyc - e.start_cyc, e.lat);
        check({e.name, ".error"}, 32'(bus.error), 32'(e.err));
        check({e.name, ".bad_digit"}, 32'(bus.bad_digit), 32'(e.bad));
        check({e.name, ".mins"}, 32'(bus.stopwatch_unit_mins), e.mins);
        check({e.name, ".secs"}, 32'(bus.stopwatch_unit_secs), e.secs);
        check({e.name, ".decs"}, 32'(bus.stopwatch_unit_decs), e.decs);
      end
    end
  end

  task automatic set_hex(input logic [47:0] hx);
    {bus.hex_10_mins, bus.hex_1_min, bus.hex_10_secs,
     bus.hex_1_sec, bus.hex_tenths, bus.hex_hundredths} = hx;
  endtask

  // Issue one start pulse; inputs are scrambled right after so late changes are exercised.
  task automatic issue(input string name, input logic [47:0] hx, input logic push,
                       input logic err, input logic [5:0] bad,
                       input int unsigned m, input int unsigned s, input int unsigned d);
    exp_t e;
    @(negedge clock);
    set_hex(hx);
    bus.start = 1'b1;
    if (push) begin
      e.name = name; e.start_cyc = cyc; e.lat = err ? 2 : 9;
      e.err = err; e.bad = bad; e.mins = m; e.secs = s; e.decs = d;
      sb.push_back(e);
      accepted++;
    end
    @(negedge clock);
    bus.start = 1'b0;
    set_hex(48'h00_11_22_33_44_55);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s.timeout: got %0d pending, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    bus.start = 1'b0;
    set_hex(48'hFF_FF_FF_FF_FF_FF);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.done", 32'(bus.done), 0);
    check("reset.error", 32'(bus.error), 0);
    check("reset.bad_digit", 32'(bus.bad_digit), 0);
    check("reset.mins", 32'(bus.stopwatch_unit_mins), 0);
    check("reset.secs", 32'(bus.stopwatch_unit_secs), 0);
    check("reset.decs", 32'(bus.stopwatch_unit_decs), 0);

    issue("t12_34_56", 48'hF9_A4_B0_99_92_82, 1'b1, 1'b0, 6'b000000, 12, 34, 56);
    drain("t12_34_56");
    issue("max", 48'h90_90_92_90_90_90, 1'b1, 1'b0, 6'b000000, 99, 59, 99);
    drain("max");
    issue("tensec6", 48'hF9_A4_82_99_92_82, 1'b1, 1'b1, 6'b001000, 99, 59, 99);
    drain("tensec6");
    issue("garbage", 48'hF9_FE_B0_99_92_82, 1'b1, 1'b1, 6'b010000, 99, 59, 99);
    drain("garbage");
`ifdef SEG_DECODER_BLANK_ZERO_EN
    issue("blank", 48'hFF_C0_C0_92_C0_F8, 1'b1, 1'b0, 6'b000000, 0, 5, 7);
`else
    issue("blank", 48'hFF_C0_C0_92_C0_F8, 1'b1, 1'b1, 6'b100000, 99, 59, 99);
`endif
    drain("blank");
    issue("altcodes", 48'hC0_D8_C0_83_80_98, 1'b1, 1'b0, 6'b000000, 7, 6, 89);
    drain("altcodes");

    // Reset during CONVERT: everything returns to zero and no done appears.
    issue("midreset", 48'hF9_A4_B0_99_92_82, 1'b0, 1'b0, 6'b0, 0, 0, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset.busy", 32'(bus.busy), 0);
    check("midreset.done", 32'(bus.done), 0);
    check("midreset.mins", 32'(bus.stopwatch_unit_mins), 0);
    check("midreset.secs", 32'(bus.stopwatch_unit_secs), 0);
    check("midreset.decs", 32'(bus.stopwatch_unit_decs), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    check("midreset.idle_busy", 32'(bus.busy), 0);

    // A second start while busy must be dropped, not queued.
    issue("busyign", 48'h90_90_92_90_90_90, 1'b1, 1'b0, 6'b000000, 99, 59, 99);
    @(negedge clock);
    check("busyign.busy", 32'(bus.busy), 1);
    set_hex(48'hF9_A4_B0_99_92_82);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    drain("busyign");
    repeat (15) @(negedge clock);
    check("done_count", done_seen, accepted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
    $fatal(1);
  end

endmodule
